sand_sweep_ctrl: RTL and testbench

SAND_SWEEP_CTRL -- requirements
Module: sand_sweep_ctrl

---
 rtl/sand_sweep_ctrl_if.sv | 21 ++
 rtl/sand_sweep_ctrl.sv | 147 ++++++++++++++
 tb/tb_sand_sweep_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/sand_sweep_ctrl_if.sv
// rtl/sand_sweep_ctrl_if.sv - tile RAM strobes and tile processor handshake between sweep controller and datapath
interface sand_sweep_ctrl_if;
  logic [9:0] tile_addr;
  logic       read_tile;
  logic       write_tile;
  logic       reset_tile;
  logic       read_ram_a;
  logic       proc_valid;
  logic       proc_ready;
  logic       proc_changed;

  modport master (
    output tile_addr, read_tile, write_tile, reset_tile, read_ram_a, proc_valid,
    input  proc_ready, proc_changed
  );

  modport slave (
    input  tile_addr, read_tile, write_tile, reset_tile, read_ram_a, proc_valid,
    output proc_ready, proc_changed
  );
endinterface

// File: rtl/sand_sweep_ctrl.sv
// rtl/sand_sweep_ctrl.sv - double-buffered tile grid sweep controller (clear, read/process/write, bank swap)
// Optional feature macro: SANDCTRL_AUTOSTOP_EN ends a run after a sweep that changed no tile.
module sand_sweep_ctrl #(
  parameter int NUM_TILES = 1024,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 clear_req,
  input  logic                 stop_req,
  sand_sweep_ctrl_if.master    bus,
  output logic                 busy,
  output logic                 sweep_done,
  output logic                 stable,
  output logic [CNT_W-1:0]     sweep_count
);

  typedef enum logic [2:0] {IDLE, CLEAR, READ, WAIT, WRITE, SWAP} state_t;

  localparam logic [9:0]       LAST_TILE = 10'(NUM_TILES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           state, state_nx;
  logic [9:0]       addr, addr_nx;
  logic             bank, bank_nx;
  logic             dirty, dirty_nx;
  logic             stop_seen, stop_seen_nx;
  logic             stable_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             auto_stop;

`ifdef SANDCTRL_AUTOSTOP_EN
  assign auto_stop = stable;
`else
  assign auto_stop = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= '0;
      bank      <= 1'b1;
      dirty     <= 1'b0;
      stop_seen <= 1'b0;
      stable    <= 1'b0;
      cnt       <= '0;
    end else begin
      state     <= state_nx;
      addr      <= addr_nx;
      bank      <= bank_nx;
      dirty     <= dirty_nx;
      stop_seen <= stop_seen_nx;
      stable    <= stable_nx;
      cnt       <= cnt_nx;
    end
  end

  // Strobes are decoded from the next state so each one is a flop output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.read_tile  <= 1'b0;
      bus.write_tile <= 1'b0;
      bus.reset_tile <= 1'b0;
      bus.proc_valid <= 1'b0;
      busy           <= 1'b0;
      sweep_done     <= 1'b0;
    end else begin
      bus.read_tile  <= (state_nx == READ) || (state_nx == WAIT);
      bus.write_tile <= (state_nx == WRITE);
      bus.reset_tile <= (state_nx == CLEAR);
      bus.proc_valid <= (state_nx == WAIT);
      busy           <= (state_nx != IDLE);
      sweep_done     <= (state_nx == SWAP);
    end
  end

  always_comb begin
    state_nx     = state;
    addr_nx      = addr;
    bank_nx      = bank;
    dirty_nx     = dirty;
    stop_seen_nx = stop_seen | stop_req;
    stable_nx    = stable;
    cnt_nx       = cnt;
    case (state)
      IDLE: begin
        stop_seen_nx = 1'b0;
        if (clear_req) begin
          state_nx = CLEAR;
          addr_nx  = '0;
          bank_nx  = 1'b1;
        end else if (start) begin
          state_nx  = READ;
          addr_nx   = '0;
          cnt_nx    = '0;
          stable_nx = 1'b0;
          dirty_nx  = 1'b0;
        end
      end
      CLEAR: begin
        addr_nx = addr + 10'd1;
        if (addr == LAST_TILE) begin
          addr_nx = '0;
          // Bank 1 pass zeroes B, bank 0 pass zeroes A and finishes the clear.
          if (bank) begin
            bank_nx = 1'b0;
          end else begin
            bank_nx  = 1'b1;
            state_nx = IDLE;
          end
        end
      end
      READ: state_nx = WAIT;
      WAIT: begin
        if (bus.proc_ready) begin
          dirty_nx = dirty | bus.proc_changed;
          state_nx = WRITE;
        end
      end
      WRITE: begin
        if (addr == LAST_TILE) begin
          state_nx  = SWAP;
          addr_nx   = '0;
          bank_nx   = ~bank;
          cnt_nx    = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
          stable_nx = ~dirty;
          dirty_nx  = 1'b0;
        end else begin
          addr_nx  = addr + 10'd1;
          state_nx = READ;
        end
      end
      SWAP: begin
        stop_seen_nx = 1'b0;
        if (stop_seen || stop_req || auto_stop) state_nx = IDLE;
        else                                    state_nx = READ;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.tile_addr  = addr;
  assign bus.read_ram_a = bank;
  assign sweep_count    = cnt;

endmodule

// File: tb/tb_sand_sweep_ctrl.sv
// tb/tb_sand_sweep_ctrl.sv - randomized trace-level checking of sand_sweep_ctrl with NUM_TILES=4
module tb_sand_sweep_ctrl;
  localparam int N  = 4;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, clear_req = 1'b0, stop_req = 1'b0;
  logic busy, sweep_done, stable;
  logic [CW-1:0] sweep_count;

  sand_sweep_ctrl_if bus();

  sand_sweep_ctrl #(.NUM_TILES(N), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear_req(clear_req), .stop_req(stop_req),
    .bus(bus), .busy(busy), .sweep_done(sweep_done), .stable(stable), .sweep_count(sweep_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic busy, rd, wr, rs, pv, done, stab, bank;
    logic [9:0]    addr;
    logic [CW-1:0] cnt;
  } obs_t;

  typedef struct packed {
    logic ready, changed, stop, start, clear;
  } drv_t;

  obs_t exp_q[$];
  drv_t drv_q[$];
  int n_checks = 0;
  int n_pass = 0;
  logic          m_bank;
  logic [CW-1:0] m_cnt;
  logic          m_stable;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, want);
  endtask

  function automatic obs_t sample();
    obs_t o;
    o = '{busy, bus.read_tile, bus.write_tile, bus.reset_tile, bus.proc_valid, sweep_done,
          stable, bus.read_ram_a, bus.tile_addr, sweep_count};
    return o;
  endfunction

  function automatic obs_t mk(logic b, logic rd, logic wr, logic rs, logic pv, logic dn, int a);
    obs_t o;
    o = '{b, rd, wr, rs, pv, dn, m_stable, m_bank, 10'(a), m_cnt};
    return o;
  endfunction

  // Inputs that a busy controller must ignore: stray ready/changed, start and clear.
  function automatic drv_t noise();
    drv_t d;
    d.ready   = 1'($urandom_range(0, 1));
    d.changed = 1'($urandom_range(0, 1));
    d.stop    = 1'b0;
    d.start   = ($urandom_range(0, 3) == 0);
    d.clear   = ($urandom_range(0, 3) == 0);
    return d;
  endfunction

  task automatic push(input obs_t o, input drv_t d);
    exp_q.push_back(o);
    drv_q.push_back(d);
  endtask

  task automatic build_run(input int stop_sweep, input bit all_chg);
    drv_t dv;
    bit   dirty, clean, c, fin;
    int   d, stop_tile;
    m_cnt = '0;
    m_stable = 1'b0;
    for (int s = 1; s <= stop_sweep; s++) begin
      stop_tile = $urandom_range(0, N - 1);
      dirty = 0;
      clean = !all_chg && ($urandom_range(0, 2) == 0);
      for (int t = 0; t < N; t++) begin
        c = all_chg ? 1'b1 : (clean ? 1'b0 : 1'($urandom_range(0, 1)));
        d = $urandom_range(0, 1) ? 0 : $urandom_range(1, 4);
        dv = noise();
        dv.stop = (s == stop_sweep) && (t == stop_tile);
        push(mk(1, 1, 0, 0, 0, 0, t), dv);
        for (int w = 0; w <= d; w++) begin
          dv = noise();
          dv.ready = (w == d);
          if (w == d) dv.changed = c;
          push(mk(1, 1, 0, 0, 1, 0, t), dv);
        end
        dirty |= c;
        push(mk(1, 0, 1, 0, 0, 0, t), noise());
      end
      m_bank   = ~m_bank;
      m_cnt    = m_cnt + 1;
      m_stable = ~dirty;
      push(mk(1, 0, 0, 0, 0, 1, 0), noise());
      fin = 0;
`ifdef SANDCTRL_AUTOSTOP_EN
      if (!dirty) fin = 1;
`endif
      if (fin) break;
    end
    push(mk(0, 0, 0, 0, 0, 0, 0), '0);
  endtask

  task automatic build_clear();
    for (int p = 0; p < 2; p++) begin
      for (int t = 0; t < N; t++) begin
        m_bank = (p == 0);
        push(mk(1, 0, 0, 1, 0, 0, t), noise());
      end
    end
    m_bank = 1'b1;
    push(mk(0, 0, 0, 0, 0, 0, 0), '0);
  endtask

  task automatic apply(input drv_t d);
    bus.proc_ready   = d.ready;
    bus.proc_changed = d.changed;
    stop_req         = d.stop;
    start            = d.start;
    clear_req        = d.clear;
  endtask

  task automatic execute(input string tag, input logic do_start, input logic do_clear);
    start     = do_start;
    clear_req = do_clear;
    for (int k = 0; k < exp_q.size(); k++) begin
      @(posedge clk);
      #1;
      check_eq(tag, 64'(sample()), 64'(exp_q[k]));
      apply(drv_q[k]);
    end
    exp_q.delete();
    drv_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic found;
    bus.proc_ready = 1'b0;
    bus.proc_changed = 1'b0;
    m_bank = 1'b1; m_cnt = '0; m_stable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset", 64'(sample()), 64'(mk(0, 0, 0, 0, 0, 0, 0)));
    rst_n = 1'b1;
    @(posedge clk); #1;

    build_clear();
    execute("clear", 1'b0, 1'b1);
    build_run(3, 1'b1);
    execute("sweep_all_changed", 1'b1, 1'b0);
    build_clear();
    execute("start_with_clear", 1'b1, 1'b1);

    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bus.proc_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #1;
      if (bus.proc_valid && bus.tile_addr == 10'd1) found = 1'b1;
    end
    bus.proc_ready = 1'b0;
    check_eq("reach_wait_tile1", 64'(found), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    m_bank = 1'b1; m_cnt = '0; m_stable = 1'b0;
    check_eq("reset_async", 64'(sample()), 64'(mk(0, 0, 0, 0, 0, 0, 0)));
    @(posedge clk); #1;
    check_eq("reset_hold", 64'(sample()), 64'(mk(0, 0, 0, 0, 0, 0, 0)));
    rst_n = 1'b1;
    @(posedge clk); #1;

    build_run(2, 1'b0);
    execute("run_after_reset", 1'b1, 1'b0);
    repeat (25) begin
      if ($urandom_range(0, 4) == 0) begin
        build_clear();
        execute("rand_clear", 1'($urandom_range(0, 1)), 1'b1);
      end else begin
        build_run($urandom_range(1, 3), 1'b0);
        execute("rand_run", 1'b1, 1'b0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
